// File: rtl/nn_upscale3x_stream.sv
// 3x nearest-neighbour upscaler: each pixel is emitted 3 times per line, and each line 3 times.
// The first copy of a line streams from the input hold register. The two repeats replay the line buffer.
module nn_upscale3x_stream #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_sol,
    output logic             out_eol,
    output logic [1:0]       rep_phase,
    output logic [1:0]       row_phase
);

    localparam int              CW        = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CW-1:0]   COL_LAST  = CW'(IMG_W - 1);
    localparam logic [1:0]      ROW_FILL  = 2'd0;
    localparam logic [1:0]      ROW_LAST  = 2'd2;
    localparam logic [1:0]      PH_LAST   = 2'd2;

    logic [CW-1:0]    col_q, col_d;
    logic [1:0]       hph_q, hph_d;
    logic [1:0]       vrow_q, vrow_d;
    logic             hold_valid_q, hold_valid_d;
    logic [PIX_W-1:0] hold_pix_q, hold_pix_d;
    logic [PIX_W-1:0] line_mem [IMG_W];

    logic             fill, last_ph, last_col, xfer, accept;
    logic [CW-1:0]    wr_addr;

    always_comb begin
        fill      = (vrow_q == ROW_FILL);
        last_ph   = (hph_q == PH_LAST);
        last_col  = (col_q == COL_LAST);
        out_valid = fill ? hold_valid_q : 1'b1;
        xfer      = out_valid & out_ready;
        // Prefetch the next pixel on the final copy of the current one, except at end of line
        in_ready  = fill & (!hold_valid_q | (xfer & last_ph & !last_col));
        accept    = in_valid & in_ready;
        // An accept during a held pixel belongs to the next column
        wr_addr   = hold_valid_q ? (col_q + CW'(1)) : col_q;
        out_pixel = fill ? hold_pix_q : line_mem[col_q];
        out_sol   = out_valid & (col_q == '0) & (hph_q == 2'd0);
        out_eol   = out_valid & last_col & last_ph;
        rep_phase = hph_q;
        row_phase = vrow_q;

        col_d        = col_q;
        hph_d        = hph_q;
        vrow_d       = vrow_q;
        hold_valid_d = hold_valid_q;
        hold_pix_d   = hold_pix_q;

        if (xfer) begin
            if (last_ph) begin
                hph_d = 2'd0;
                if (last_col) begin
                    col_d  = '0;
                    vrow_d = (vrow_q == ROW_LAST) ? ROW_FILL : (vrow_q + 2'd1);
                end else begin
                    col_d = col_q + CW'(1);
                end
                if (fill)
                    hold_valid_d = 1'b0;
            end else begin
                hph_d = hph_q + 2'd1;
            end
        end

        if (accept) begin
            hold_valid_d = 1'b1;
            hold_pix_d   = in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            hph_q        <= 2'd0;
            vrow_q       <= ROW_FILL;
            hold_valid_q <= 1'b0;
            hold_pix_q   <= '0;
        end else begin
            col_q        <= col_d;
            hph_q        <= hph_d;
            vrow_q       <= vrow_d;
            hold_valid_q <= hold_valid_d;
            hold_pix_q   <= hold_pix_d;
        end
    end

    // Line buffer is deliberately left uninitialised; every replay is preceded by a full fill
    always_ff @(posedge clk) begin
        if (accept)
            line_mem[wr_addr] <= in_pixel;
    end

endmodule
